md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 51 +++++
 rtl/md_unit_if.sv | 13 +
 rtl/md_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the divide helper used when an operation is accepted.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Returns {remainder, quotient}. Zero divisor yields zero (the caller
  // suppresses the HI/LO write). The one signed overflow case is pinned so
  // the result never depends on host arithmetic behaviour.
  function automatic logic [63:0] md_divide(input logic [31:0] dividend,
                                            input logic [31:0] divisor,
                                            input logic        is_signed);
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [63:0]        res;
    sq  = 32'sd0;
    sr  = 32'sd0;
    res = 64'd0;
    if (divisor == 32'd0) begin
      res = 64'd0;
    end else if (is_signed) begin
      if ((dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
        res = {32'h0000_0000, 32'h8000_0000};
      end else begin
        sq  = $signed(dividend) / $signed(divisor);
        sr  = $signed(dividend) % $signed(divisor);
        res = {sr, sq};
      end
    end else begin
      res = {dividend % divisor, dividend / divisor};
    end
    return res;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed and latched when the op is accepted; it is only
// committed to HI/LO when the busy countdown expires, so the pipeline sees
// the same latency as an iterative unit.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    res_hi_q, res_hi_d;
  logic [31:0]    res_lo_q, res_lo_d;
  logic           res_wr_q, res_wr_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic           busy_q, busy_d;

  logic [63:0]    prod_s;
  logic [63:0]    prod_u;
  logic [63:0]    quot_rem;

  // Operand arithmetic: low 64 bits of the sign-extended product equal the signed product.
  always_comb begin
    prod_s   = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
    prod_u   = {32'd0, md.src_a} * {32'd0, md.src_b};
    quot_rem = md_divide(md.src_a, md.src_b, (md.md_op == MD_DIV));
  end

  // Next-state, countdown, result latch and HI/LO commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          case (md.md_op)
            MD_MULT: begin
              state_d  = ST_MUL;
              cnt_d    = CNT_W'(MULT_CYCLES);
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
              res_wr_d = 1'b1;
            end
            MD_MULTU: begin
              state_d  = ST_MUL;
              cnt_d    = CNT_W'(MULT_CYCLES);
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
              res_wr_d = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d  = ST_DIV;
              cnt_d    = CNT_W'(DIV_CYCLES);
              res_hi_d = quot_rem[63:32];
              res_lo_d = quot_rem[31:0];
              res_wr_d = (md.src_b != 32'd0);
            end
            MD_MTHI: hi_d = md.src_a;
            MD_MTLO: lo_d = md.src_a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
